// File: rtl/pipe_scoreboard.sv
// Register-write scoreboard for an in-order pipeline: per-register in-flight write
// counters drive a combinational freeze on RAW hazards and counter/total saturation.
module pipe_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 2,
  parameter int OUT_W     = 4,
  parameter int WB_BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_wb_en,
  input  logic [REG_AW-1:0]      issue_dst,
  input  logic [REG_AW-1:0]      issue_src1,
  input  logic [REG_AW-1:0]      issue_src2,
  input  logic                   src2_used,
  input  logic                   cancel,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_dst,
  output logic                   freeze,
  output logic [2**REG_AW-1:0]   pending,
  output logic [OUT_W-1:0]       outstanding,
  output logic                   err_underflow
);

  localparam int NREGS = 2**REG_AW;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [OUT_W-1:0] OMAX = '1;

  logic [CNT_W-1:0] cnt     [NREGS];
  logic [CNT_W-1:0] cnt_nxt [NREGS];
  logic [OUT_W-1:0] out_q, out_nxt;
  logic             err_q;

  logic wb_hit, dec, underflow, inc;
  logic byp1, byp2, hz1, hz2, st_dst, st_out;

  always_comb begin
    wb_hit    = wb_valid && (wb_dst != '0);
    dec       = wb_hit && (cnt[wb_dst] != '0);
    underflow = wb_hit && (cnt[wb_dst] == '0);

    // A writeback retiring the last in-flight write to a source frees it this cycle.
    byp1 = (WB_BYPASS != 0) && wb_valid && (wb_dst == issue_src1)
           && (cnt[issue_src1] == CNT_W'(1));
    byp2 = (WB_BYPASS != 0) && wb_valid && (wb_dst == issue_src2)
           && (cnt[issue_src2] == CNT_W'(1));
    hz1  = (cnt[issue_src1] != '0) && !byp1;
    hz2  = src2_used && (cnt[issue_src2] != '0) && !byp2;

    st_dst = issue_wb_en && (cnt[issue_dst] == CMAX) && !(dec && (wb_dst == issue_dst));
    st_out = (out_q == OMAX) && !dec;

    freeze = !rst && issue_valid && !cancel && (hz1 || hz2 || st_dst || st_out);
    inc    = issue_valid && !cancel && !freeze && issue_wb_en && (issue_dst != '0);
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_nxt[i] = cnt[i] + CNT_W'(inc && (issue_dst == REG_AW'(i)))
                          - CNT_W'(dec && (wb_dst == REG_AW'(i)));
    end
    cnt_nxt[0] = '0;
    out_nxt    = out_q + OUT_W'(inc) - OUT_W'(dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) cnt[i] <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) cnt[i] <= cnt_nxt[i];
      out_q <= out_nxt;
      if (underflow) err_q <= 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) pending[i] = (cnt[i] != '0);
  end

  assign outstanding   = out_q;
  assign err_underflow = err_q;

endmodule
